busca_instrucao: RTL and testbench

Instruction-fetch stage directly upstream of the control decoder. It holds the PC and issues one-at-a-time requests to instruction memory, which may have variable latency. Returned words go into a 2-entry in-order buffer. The buffer head is presented to decode with valid/ready, with opcode/funct3/funct7 split out for the control unit. A taken-branch (bne) redirect from execute flushes the stage and restarts fetch at the target.

---
 rtl/busca_instrucao.sv | 163 ++++++++++++++++
 tb/tb_busca_instrucao.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao -- instruction-fetch stage feeding the control decoder.
//
// Holds the PC, issues one instruction-memory request at a time (variable
// latency, req/ack handshake), queues returned words in a 2-entry in-order
// buffer and presents the head to decode with valid/ready. A taken-branch
// pulse from execute flushes the stage and restarts fetch at the target.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_req/mem_addr  request to instruction memory, held stable until ack
//   mem_ack/mem_dado  single-cycle completion with the instruction word
//   desvio_tomado     single-cycle redirect pulse, target in alvo_desvio
//   inst_valida       buffer head valid towards decode
//   decod_pronto      decode accepts the head this cycle
//   instrucao/pc_inst buffer head word and its address
//   opcode/funct3/funct7  fields of the head word for the control unit
// -----------------------------------------------------------------------------
module busca_instrucao #(
   parameter int                    LARGURA_PC = 32,
   parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [LARGURA_PC-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [LARGURA_PC-1:0] mem_dado,
   input  logic                  desvio_tomado,
   input  logic [LARGURA_PC-1:0] alvo_desvio,
   output logic                  inst_valida,
   input  logic                  decod_pronto,
   output logic [LARGURA_PC-1:0] instrucao,
   output logic [LARGURA_PC-1:0] pc_inst,
   output logic [6:0]            opcode,
   output logic [2:0]            funct3,
   output logic [6:0]            funct7
);

   localparam logic [1:0] INICIO   = 2'd0;
   localparam logic [1:0] BUSCA    = 2'd1;
   localparam logic [1:0] OCIOSO   = 2'd2;
   localparam logic [1:0] DESCARTA = 2'd3;

   typedef struct packed {
      logic [LARGURA_PC-1:0] palavra;
      logic [LARGURA_PC-1:0] pc;
   } entrada_t;

   logic [1:0]            estado_q, estado_d;
   logic [LARGURA_PC-1:0] pc_q, pc_d;
   logic [LARGURA_PC-1:0] addr_desc_q, addr_desc_d;  // address of the flushed request
   logic [1:0]            cont_q, cont_d;            // buffer occupancy 0..2
   entrada_t              ent0_q, ent0_d;            // head, always at slot 0
   entrada_t              ent1_q, ent1_d;

   logic                  pop, push;
   logic [LARGURA_PC-1:0] alvo;
   entrada_t              nova;

   // Low two target bits are forced to zero so every fetch stays word aligned.
   assign alvo = alvo_desvio & ~LARGURA_PC'(3);
   assign nova = '{palavra: mem_dado, pc: pc_q};

   // A redirect voids any pop and any push in the same cycle.
   assign pop  = inst_valida & decod_pronto & ~desvio_tomado;
   assign push = (estado_q == BUSCA) & mem_ack & ~desvio_tomado;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      estado_d    = estado_q;
      pc_d        = pc_q;
      addr_desc_d = addr_desc_q;
      cont_d      = cont_q;
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;

      if (desvio_tomado) begin
         cont_d = 2'd0;
         pc_d   = alvo;
         case (estado_q)
            BUSCA: begin
               // Outstanding request must still be completed, but its data dropped.
               if (!mem_ack) begin
                  estado_d    = DESCARTA;
                  addr_desc_d = pc_q;
               end
            end
            DESCARTA: estado_d = DESCARTA;
            default:  estado_d = BUSCA;
         endcase
      end else begin
         // Slot 0 only shifts when slot 1 holds a live entry, so the head
         // outputs keep their last value once the buffer drains.
         case ({push, pop})
            2'b10: begin
               if (cont_q == 2'd0) ent0_d = nova;
               else                ent1_d = nova;
               cont_d = cont_q + 2'd1;
            end
            2'b01: begin
               if (cont_q == 2'd2) ent0_d = ent1_q;
               cont_d = cont_q - 2'd1;
            end
            2'b11: begin
               if (cont_q == 2'd1) begin
                  ent0_d = nova;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = nova;
               end
            end
            default: ;
         endcase

         case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
               if (mem_ack) begin
                  pc_d = pc_q + LARGURA_PC'(4);
                  if (cont_d == 2'd2) estado_d = OCIOSO;
               end
            end
            OCIOSO:   if (pop) estado_d = BUSCA;
            DESCARTA: if (mem_ack) estado_d = BUSCA;
            default:  estado_d = INICIO;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= INICIO;
         pc_q        <= PC_INICIAL;
         addr_desc_q <= '0;
         cont_q      <= 2'd0;
         // NOTE: the buffer entries are reset because slot 0 drives the
         // registered head outputs, which must read zero out of reset.
         ent0_q      <= '0;
         ent1_q      <= '0;
      end else begin
         estado_q    <= estado_d;
         pc_q        <= pc_d;
         addr_desc_q <= addr_desc_d;
         cont_q      <= cont_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
      end
   end

   assign mem_req     = (estado_q == BUSCA) || (estado_q == DESCARTA);
   assign mem_addr    = (estado_q == DESCARTA) ? addr_desc_q : pc_q;
   assign inst_valida = (cont_q != 2'd0);
   assign instrucao   = ent0_q.palavra;
   assign pc_inst     = ent0_q.pc;
   assign opcode      = ent0_q.palavra[6:0];
   assign funct3      = ent0_q.palavra[14:12];
   assign funct7      = ent0_q.palavra[31:25];

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao -- self-checking bench for busca_instrucao.
// The reference model is a program-order stream: every instruction accepted by
// decode must be the memory word at the next expected PC, which advances by 4
// and jumps to the word-aligned target on each redirect.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_dado;
   logic        desvio_tomado;
   logic [31:0] alvo_desvio;
   logic        inst_valida;
   logic        decod_pronto;
   logic [31:0] instrucao;
   logic [31:0] pc_inst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   // Second instance for the PC wrap-around case.
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_dado;
   logic        w_valid;
   logic [31:0] w_word;
   logic [31:0] w_pc;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;

   busca_instrucao #(.LARGURA_PC(32), .PC_INICIAL(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dado(mem_dado),
      .desvio_tomado(desvio_tomado), .alvo_desvio(alvo_desvio),
      .inst_valida(inst_valida), .decod_pronto(decod_pronto),
      .instrucao(instrucao), .pc_inst(pc_inst),
      .opcode(opcode), .funct3(funct3), .funct7(funct7)
   );

   busca_instrucao #(.LARGURA_PC(32), .PC_INICIAL(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_dado(w_dado),
      .desvio_tomado(1'b0), .alvo_desvio(32'h0),
      .inst_valida(w_valid), .decod_pronto(1'b0),
      .instrucao(w_word), .pc_inst(w_pc),
      .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   // Memory model and stimulus knobs
   int          mem_lat  = 0;
   bit          mem_rand = 0;
   bit          dp       = 1;
   bit          dp_rand  = 0;
   bit          br_now   = 0;
   logic [31:0] br_target = '0;
   bit          pending  = 0;
   int          wait_cnt = 0;
   int          cur_lat  = 0;
   bit          hold_chk = 0;
   logic [31:0] hold_addr = '0;
   bit          expect_empty = 0;
   logic [31:0] exp_pc = '0;

   // Snapshot of the DUT taken at the falling edge of the last cycle
   logic        s_req, s_valid, s_ack;
   logic [31:0] s_addr, s_word, s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h40A3_0333;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // One clock cycle: sample at negedge, drive memory/decode/redirect,
   // update the program-order model, then wait for the rising edge.
   task automatic cycle();
      logic pop;
      @(negedge clk);
      s_req   = mem_req;
      s_addr  = mem_addr;
      s_valid = inst_valida;
      s_word  = instrucao;
      s_pc    = pc_inst;

      if (hold_chk) begin
         n_tests++;
         if (!(s_req === 1'b1 && s_addr === hold_addr)) begin
            n_fail++;
            $display("FAIL addr_hold: req=%b addr=%h, required req=1 addr=%h", s_req, s_addr, hold_addr);
         end
      end

      mem_ack = 1'b0;
      if (s_req) begin
         if (!pending) begin
            pending  = 1;
            wait_cnt = 0;
            cur_lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
         end
         if (wait_cnt >= cur_lat) begin
            mem_ack  = 1'b1;
            mem_dado = mem_word(s_addr);
            pending  = 0;
         end else begin
            wait_cnt++;
         end
      end
      s_ack     = mem_ack;
      hold_chk  = s_req && !mem_ack;
      hold_addr = s_addr;

      desvio_tomado = br_now;
      alvo_desvio   = br_target;
      br_now        = 0;
      decod_pronto  = dp_rand ? 1'($urandom_range(0, 1)) : dp;

      if (expect_empty) begin
         n_tests++;
         if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: inst_valida=%b, required 0", s_valid);
         end
         expect_empty = 0;
      end

      if (s_valid) begin
         n_tests++;
         if (opcode !== s_word[6:0] || funct3 !== s_word[14:12] || funct7 !== s_word[31:25]) begin
            n_fail++;
            $display("FAIL fields: op=%h f3=%h f7=%h for word %h", opcode, funct3, funct7, s_word);
         end
      end

      pop = s_valid && decod_pronto && !desvio_tomado;
      if (pop) begin
         n_pops++;
         n_tests++;
         if (s_pc !== exp_pc || s_word !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL order: pc_inst=%h instrucao=%h, required pc %h word %h",
                     s_pc, s_word, exp_pc, mem_word(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
      if (desvio_tomado) begin
         exp_pc       = alvo_desvio & ~32'h3;
         expect_empty = 1;
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_ack = 1'b0; desvio_tomado = 1'b0; w_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pending = 0; hold_chk = 0; expect_empty = 0; br_now = 0;
      exp_pc = 32'h0;
   endtask

   // Spins until a request is seen; counts an expired bound as a failure.
   task automatic wait_req(input string name);
      int k = 0;
      cycle();
      while (!s_req && k < 20) begin
         cycle();
         k++;
      end
      if (!s_req) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: mem_req never rose", name);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ack = 1'b0; mem_dado = '0; desvio_tomado = 1'b0; alvo_desvio = '0;
      decod_pronto = 1'b0; w_ack = 1'b0; w_dado = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b0 || inst_valida !== 1'b0 || instrucao !== 32'h0 || pc_inst !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h, required 0 0 0 0",
                  mem_req, inst_valida, instrucao, pc_inst);
      end
      rst_n = 1'b1;
      exp_pc = 32'h0;
   endtask

   task automatic test_stream();
      logic [31:0] addrs [3];
      do_reset();
      mem_rand = 0; mem_lat = 0; dp_rand = 0; dp = 1;
      wait_req("stream");
      addrs[0] = s_addr;
      n_tests++;
      if (s_valid !== 1'b0) begin
         n_fail++; $display("FAIL stream_first_valid: inst_valida=%b, required 0", s_valid);
      end
      for (int i = 1; i < 4; i++) begin
         cycle();
         if (i < 3) addrs[i] = s_addr;
         n_tests++;
         if (s_valid !== 1'b1 || s_pc !== 32'((i - 1) * 4)) begin
            n_fail++;
            $display("FAIL stream_head%0d: valid=%b pc_inst=%h, required 1 %h", i, s_valid, s_pc, 32'((i - 1) * 4));
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (addrs[i] !== 32'(i * 4)) begin
            n_fail++; $display("FAIL stream_addr%0d: mem_addr=%h, required %h", i, addrs[i], 32'(i * 4));
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      mem_rand = 0; mem_lat = 0; dp_rand = 0; dp = 0;
      wait_req("full");
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_tests++;
         if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL full_idle%0d: req=%b valid=%b pc_inst=%h, required 0 1 00000000", i, s_req, s_valid, s_pc);
         end
      end
      dp = 1;
      cycle();
      cycle();
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'h8 || s_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL full_resume: req=%b addr=%h pc_inst=%h, required 1 00000008 00000004", s_req, s_addr, s_pc);
      end
      repeat (4) cycle();
   endtask

   task automatic test_flush_pending();
      int k = 0;
      do_reset();
      mem_rand = 0; mem_lat = 3; dp_rand = 0; dp = 1;
      cycle();
      while (!(s_req && s_addr == 32'h8) && k < 40) begin
         cycle();
         k++;
      end
      br_now = 1; br_target = 32'h43;
      cycle();
      k = 0;
      while (!s_ack && k < 10) begin
         cycle();
         k++;
         n_tests++;
         if (s_addr !== 32'h8) begin
            n_fail++; $display("FAIL flush_hold: mem_addr=%h, required 00000008", s_addr);
         end
      end
      cycle();
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'h40 || s_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_restart: req=%b addr=%h valid=%b, required 1 00000040 0", s_req, s_addr, s_valid);
      end
      repeat (12) cycle();
   endtask

   task automatic test_flush_ack();
      do_reset();
      mem_rand = 0; mem_lat = 0; dp_rand = 0; dp = 1;
      wait_req("flush_ack");
      br_now = 1; br_target = 32'h100;
      cycle();
      n_tests++;
      if (s_addr !== 32'h4 || s_ack !== 1'b1) begin
         n_fail++; $display("FAIL flush_ack_cycle: addr=%h ack=%b, required 00000004 1", s_addr, s_ack);
      end
      cycle();
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ack_next: req=%b addr=%h valid=%b, required 1 00000100 0", s_req, s_addr, s_valid);
      end
      repeat (5) cycle();
   endtask

   task automatic test_fields();
      int k = 0;
      do_reset();
      mem_rand = 0; mem_lat = 1; dp_rand = 0; dp = 0;
      cycle();
      while (!s_valid && k < 20) begin
         cycle();
         k++;
      end
      n_tests++;
      if (opcode !== 7'h33 || funct3 !== 3'b000 || funct7 !== 7'h20 || instrucao !== 32'h40A3_0333) begin
         n_fail++;
         $display("FAIL fields_decode: op=%h f3=%h f7=%h inst=%h, required 33 0 20 40a30333",
                  opcode, funct3, funct7, instrucao);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seen [2];
      int n = 0;
      do_reset();
      for (int k = 0; k < 12 && n < 2; k++) begin
         @(negedge clk);
         w_ack = 1'b0;
         if (w_req) begin
            seen[n] = w_addr;
            n++;
            w_ack  = 1'b1;
            w_dado = mem_word(w_addr);
         end
         @(posedge clk);
      end
      @(negedge clk);
      w_ack = 1'b0;
      n_tests++;
      if (n != 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_addr: n=%0d first=%h second=%h, required 2 fffffffc 00000000", n, seen[0], seen[1]);
      end
      n_tests++;
      if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_req !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_head: valid=%b pc_inst=%h req=%b, required 1 fffffffc 0", w_valid, w_pc, w_req);
      end
   endtask

   task automatic test_async_reset();
      int k = 0;
      do_reset();
      mem_rand = 0; mem_lat = 2; dp_rand = 0; dp = 0;
      cycle();
      while (!(s_valid && s_req && !s_ack) && k < 30) begin
         cycle();
         k++;
      end
      #2;
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      mem_dado = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if (mem_req !== 1'b0 || inst_valida !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: req=%b valid=%b, required 0 0", mem_req, inst_valida);
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      rst_n   = 1'b1;
      pending = 0; hold_chk = 0; expect_empty = 0; exp_pc = 32'h0;
      mem_lat = 0; dp = 1;
      wait_req("async_reset");
      n_tests++;
      if (s_addr !== 32'h0 || s_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_restart: addr=%h valid=%b, required 00000000 0", s_addr, s_valid);
      end
      repeat (4) cycle();
   endtask

   task automatic test_random();
      int pops_before;
      do_reset();
      mem_rand = 1; dp_rand = 1;
      pops_before = n_pops;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            br_now    = 1;
            br_target = $urandom;
         end
         cycle();
      end
      n_tests++;
      if (n_pops - pops_before < 50) begin
         n_fail++;
         $display("FAIL random_progress: %0d instructions delivered, required at least 50", n_pops - pops_before);
      end
      mem_rand = 0; dp_rand = 0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_flush_pending();
      test_flush_ack();
      test_fields();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
